tx_uart_fifo: RTL and testbench

//  Next-generation UART transmitter: parametrised data width, runtime-selectable parity and stop bits,
//  and an internal TX FIFO so the CPU bus side can queue bytes without stalling per frame.

---
 rtl/tx_uart_fifo.sv | 191 +++++++++++++++++++
 tb/tb_tx_uart_fifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_uart_fifo.sv
// UART transmitter with an internal TX FIFO.
// The bus side pushes words through a valid/ready handshake. The serialiser pops the head
// word at each frame start and sends start, data (LSB first), optional parity and stop
// symbols. Frames run back-to-back while the FIFO holds data.
module tx_uart_fifo #(
    parameter int SYSTEM_CLK = 100_000_000,
    parameter int BAUDRATE   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          ready,
    input  logic [15:0]                   div,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          tx_out,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int BW      = $clog2(DATA_BITS + 1);
    localparam int DEF_CPS = SYSTEM_CLK / BAUDRATE;
    localparam logic [15:0]   DEF_CPS16 = DEF_CPS[15:0];
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // FIFO storage and pointers; pointers wrap naturally because the depth is a power of two
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;

    // Serialiser state. The per-frame settings are captured at pop so that bus-side
    // changes only affect the next frame.
    state_t               state;
    logic [16:0]          cnt;        // wide enough for 2*CPS-1 in the two-stop case
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [15:0]          cps_r;
    logic                 par_en;
    logic                 par_bit;
    logic                 two_r;

    logic [15:0]          cps_now;
    logic [16:0]          sym_reload;
    logic [16:0]          stop_reload;
    logic                 sym_end;

    // The full flag comes straight from the count, so a push while full is never accepted
    assign ready = (fifo_count != FULL_CNT);
    assign push  = valid && ready;
    assign head  = mem[rd_ptr];
    assign busy  = (state != IDLE) || (fifo_count != '0);

    // The symbol counter has reached its last cycle
    assign sym_end = (cnt == 17'd0);

    // Pop at the idle check or on the final stop cycle, which gives the zero-gap chaining
    assign pop = (fifo_count != '0) &&
                 ((state == IDLE) || ((state == STOP) && sym_end));

    // Symbol length for the frame that is about to start. div==1 is raised to 2 because
    // the counter needs at least two cycles per symbol.
    always_comb begin
        cps_now = div;
        if (div == 16'd0)
            cps_now = DEF_CPS16;
        else if (div == 16'd1)
            cps_now = 16'd2;
    end

    // Counter reload values: one symbol, or the whole stop period (one or two symbols)
    assign sym_reload  = {1'b0, cps_r} - 17'd1;
    assign stop_reload = (two_r ? {cps_r, 1'b0} : {1'b0, cps_r}) - 17'd1;

    // FIFO write port; the data array needs no reset because the pointers gate every read
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers and occupancy; a push and a pop together leave the count unchanged
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame sequencer. tx_out and tx_done are registered, so tx_out changes on the same
    // edge as the state that owns it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            tx_out  <= 1'b1;
            tx_done <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            cps_r   <= 16'd2;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            two_r   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                // Frame start: capture the word and this frame's settings, drive the start bit
                state   <= START;
                tx_out  <= 1'b0;
                cnt     <= {1'b0, cps_now} - 17'd1;
                cps_r   <= cps_now;
                shreg   <= head;
                par_en  <= parity_mode[0] ^ parity_mode[1];
                par_bit <= (^head) ^ parity_mode[1];
                two_r   <= two_stop;
            end else if (state == IDLE) begin
                tx_out <= 1'b1;
            end else if (!sym_end) begin
                cnt <= cnt - 17'd1;
                // Flag the final stop cycle one edge early so the pulse lands on that cycle
                if ((state == STOP) && (cnt == 17'd1))
                    tx_done <= 1'b1;
            end else begin
                case (state)
                    START: begin
                        state   <= DATA;
                        tx_out  <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        cnt     <= sym_reload;
                    end
                    DATA: begin
                        if (bit_idx == LAST_BIT) begin
                            if (par_en) begin
                                state  <= PARITY;
                                tx_out <= par_bit;
                                cnt    <= sym_reload;
                            end else begin
                                state  <= STOP;
                                tx_out <= 1'b1;
                                cnt    <= stop_reload;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_out  <= shreg[0];
                            shreg   <= shreg >> 1;
                            cnt     <= sym_reload;
                        end
                    end
                    PARITY: begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                        cnt    <= stop_reload;
                    end
                    default: begin
                        // End of stop with nothing queued: return to idle
                        state  <= IDLE;
                        tx_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_uart_fifo.sv
// Directed bench for tx_uart_fifo: frame format, parity, FIFO fill and backpressure,
// back-to-back frames, mid-frame reset and default-divider operation.
module tb_tx_uart_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic       valid;
    logic [7:0] tx_data;
    logic       ready;
    logic [15:0] div;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       tx_out;
    logic       busy;
    logic       tx_done;
    logic [4:0] fifo_count;

    int n_chk = 0;
    int n_err = 0;

    tx_uart_fifo #(
        .SYSTEM_CLK (1_000_000),
        .BAUDRATE   (100_000),
        .DATA_BITS  (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .valid       (valid),
        .tx_data     (tx_data),
        .ready       (ready),
        .div         (div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .tx_out      (tx_out),
        .busy        (busy),
        .tx_done     (tx_done),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; holds valid until the word is taken, returns at the next negedge
    task automatic push(input logic [7:0] d);
        int w;
        w = 0;
        tx_data = d;
        valid   = 1'b1;
        while (!ready && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (!ready)
            chk("push_timeout", {31'd0, ready}, 32'd1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Called at a negedge. Waits for a start bit, then walks the whole frame one negedge per
    // cycle: every symbol must hold for cps cycles, start must be 0, stops 1, and tx_done
    // must be high on exactly the last cycle. Returns at the first cycle after the frame.
    task automatic rx_frame(input int cps, input bit par, input bit two, input int maxwait,
                            output logic [7:0] d, output logic p, output int gap,
                            output bit ok);
        int   nsym, len, sym;
        logic first;
        ok    = 1'b1;
        gap   = 0;
        d     = '0;
        p     = 1'b0;
        first = 1'b0;
        while (tx_out !== 1'b0 && gap < maxwait) begin
            @(negedge clk);
            gap++;
        end
        if (tx_out !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        nsym = 1 + 8 + (par ? 1 : 0) + (two ? 2 : 1);
        len  = nsym * cps;
        for (int idx = 0; idx < len; idx++) begin
            sym = idx / cps;
            if (idx % cps == 0)
                first = tx_out;
            else if (tx_out !== first)
                ok = 1'b0;
            if (idx % cps == cps / 2) begin
                if (sym == 0) begin
                    if (tx_out !== 1'b0) ok = 1'b0;
                end else if (sym <= 8) begin
                    d[sym-1] = tx_out;
                end else if (par && sym == 9) begin
                    p = tx_out;
                end else if (tx_out !== 1'b1) begin
                    ok = 1'b0;
                end
            end
            if (tx_done !== (idx == len - 1))
                ok = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rd [18];
        logic       pb [18];
        int         gp [18];
        bit         okf [18];
        logic [7:0] w3 [18];

        resetn      = 1'b0;
        valid       = 1'b0;
        tx_data     = '0;
        div         = 16'd4;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", {31'd0, tx_out}, 32'd1);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        chk("rst_count", {27'd0, fifo_count}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 8N1 at 4 cycles per symbol, 0x55 alternates the line
        fork
            push(8'h55);
            rx_frame(4, 0, 0, 50, rd[0], pb[0], gp[0], okf[0]);
        join
        chk("t1_data", {24'd0, rd[0]}, 32'h55);
        chk("t1_frame", {31'd0, okf[0]}, 32'd1);
        chk("t1_latency", gp[0], 32'd2);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);

        // Even then odd parity on 0x07 (three ones)
        parity_mode = 2'b01;
        fork
            push(8'h07);
            rx_frame(4, 1, 0, 50, rd[0], pb[0], gp[0], okf[0]);
        join
        chk("t2_even_data", {24'd0, rd[0]}, 32'h07);
        chk("t2_even_par", {31'd0, pb[0]}, 32'd1);
        chk("t2_even_frame", {31'd0, okf[0]}, 32'd1);
        parity_mode = 2'b10;
        fork
            push(8'h07);
            rx_frame(4, 1, 0, 50, rd[0], pb[0], gp[0], okf[0]);
        join
        chk("t2_odd_par", {31'd0, pb[0]}, 32'd0);
        chk("t2_odd_frame", {31'd0, okf[0]}, 32'd1);

        // Three queued words, even parity, two stop bits, 3 cycles per symbol: 36-cycle frames
        parity_mode = 2'b01;
        two_stop    = 1'b1;
        div         = 16'd3;
        w3[0] = 8'h3C; w3[1] = 8'hA5; w3[2] = 8'h01;
        fork
            begin
                push(w3[0]);
                push(w3[1]);
                push(w3[2]);
            end
            for (int i = 0; i < 3; i++)
                rx_frame(3, 1, 1, 50, rd[i], pb[i], gp[i], okf[i]);
        join
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_data%0d", i), {24'd0, rd[i]}, {24'd0, w3[i]});
            chk($sformatf("t4_frame%0d", i), {31'd0, okf[i]}, 32'd1);
        end
        chk("t4_par0", {31'd0, pb[0]}, 32'd0);
        chk("t4_par2", {31'd0, pb[2]}, 32'd1);
        chk("t4_gap1", gp[1], 32'd0);
        chk("t4_gap2", gp[2], 32'd0);
        chk("t4_busy_end", {31'd0, busy}, 32'd0);

        // Fill under a stalled line, then speed up the remaining frames
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        div         = 16'd1000;
        for (int i = 0; i < 18; i++)
            w3[i] = 8'(i * 37 + 11);
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    push(w3[i]);
                    if (i == 15)
                        chk("t3_count15", {27'd0, fifo_count}, 32'd15);
                end
                chk("t3_count_full", {27'd0, fifo_count}, 32'd16);
                chk("t3_ready_full", {31'd0, ready}, 32'd0);
                div = 16'd2;
                push(w3[17]);
            end
            begin
                rx_frame(1000, 0, 0, 50, rd[0], pb[0], gp[0], okf[0]);
                for (int i = 1; i < 18; i++)
                    rx_frame(2, 0, 0, 50, rd[i], pb[i], gp[i], okf[i]);
            end
        join
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("t3_data%0d", i), {24'd0, rd[i]}, {24'd0, w3[i]});
            chk($sformatf("t3_frame%0d", i), {31'd0, okf[i]}, 32'd1);
        end
        chk("t3_empty", {27'd0, fifo_count}, 32'd0);

        // Reset in the middle of data bit 3 with words still queued
        div = 16'd4;
        fork
            begin
                push(8'h96);
                push(8'h11);
                push(8'h22);
            end
            begin
                for (int w = 0; w < 50 && tx_out !== 1'b0; w++)
                    @(negedge clk);
                repeat (17) @(negedge clk);
                resetn = 1'b0;
                @(negedge clk);
            end
        join
        chk("t5_tx_out", {31'd0, tx_out}, 32'd1);
        chk("t5_count", {27'd0, fifo_count}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_ready", {31'd0, ready}, 32'd1);
        resetn = 1'b1;
        @(negedge clk);
        fork
            push(8'hA3);
            rx_frame(4, 0, 0, 50, rd[0], pb[0], gp[0], okf[0]);
        join
        chk("t5_new_data", {24'd0, rd[0]}, 32'hA3);
        chk("t5_new_frame", {31'd0, okf[0]}, 32'd1);

        // div=0 uses SYSTEM_CLK/BAUDRATE = 10; a mid-frame change waits for the next frame
        div = 16'd0;
        fork
            push(8'h5A);
            rx_frame(10, 0, 0, 50, rd[0], pb[0], gp[0], okf[0]);
            begin
                repeat (20) @(negedge clk);
                div = 16'd4;
            end
        join
        chk("t6_data", {24'd0, rd[0]}, 32'h5A);
        chk("t6_frame", {31'd0, okf[0]}, 32'd1);
        fork
            push(8'hC3);
            rx_frame(4, 0, 0, 50, rd[1], pb[1], gp[1], okf[1]);
        join
        chk("t6_next_data", {24'd0, rd[1]}, 32'hC3);
        chk("t6_next_frame", {31'd0, okf[1]}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
